// File: rtl/serial_uart_if.sv
// CPU-side serial channel bus: one access per cycle, mode selects none/read/write.
// rdata is returned combinationally in the access cycle.
interface serial_uart_if;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output mode,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  mode,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/serial_uart.sv
// 8N1 UART responder for the serial channel: DATA/STATUS registers, TX FIFO feeding a
// transmit shifter, and a 2-flop-synchronised receiver with a single-byte holding register.
module serial_uart #(
    parameter int unsigned CLK_DIV  = 434,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    serial_uart_if.slave bus,
    output logic         txd,
    input  logic         rxd
);
    localparam int unsigned CntW  = $clog2(CLK_DIV);
    localparam int unsigned AddrW = $clog2(TX_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Bus decode
    logic acc_read, acc_write, sel_data;
    assign acc_read  = (bus.mode == 2'b01);
    assign acc_write = (bus.mode == 2'b10);
    assign sel_data  = (bus.addr[3:2] == 2'd0);

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:8]};

    // TX FIFO
    logic [7:0]      fifo_mem_q [TX_DEPTH];
    logic [7:0]      fifo_mem_d [TX_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            fifo_full, fifo_empty, push, pop;

    // TX datapath
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            txd_q, txd_d;

    // RX datapath
    rx_state_e       rx_state_q, rx_state_d;
    logic            rx_sync1_q, rx_sync1_d;
    logic            rx_sync2_q, rx_sync2_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_done;

    // Fullness is judged on the start-of-cycle pointers, so a same-cycle pop frees nothing.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign push       = acc_write && sel_data && !fifo_full;
    assign pop        = (tx_state_q == TxIdle) && !fifo_empty;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q[AddrW-1:0]] = bus.wdata[7:0];
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    // TX FSM
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    tx_shift_d = fifo_mem_q[rd_ptr_q[AddrW-1:0]];
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase

        // txd is registered from the next state so the line never glitches.
        unique case (tx_state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // RX FSM
    always_comb begin
        rx_sync1_d = rxd;
        rx_sync2_d = rx_sync1_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (!rx_sync2_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    rx_done    = rx_sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase

        // A completing byte beats a same-cycle DATA read clearing rx_valid.
        rx_data_d  = rx_done ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_valid_q;
        if (rx_done) begin
            rx_valid_d = 1'b1;
        end else if (acc_read && sel_data) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(TX_DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= RxIdle;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign txd = txd_q;

    always_comb begin
        bus.rdata = '0;
        if (acc_read) begin
            unique case (bus.addr[3:2])
                2'd0:    bus.rdata = {24'b0, rx_data_q};
                2'd1:    bus.rdata = {30'b0, rx_valid_q, !fifo_full};
                default: bus.rdata = '0;
            endcase
        end
    end
endmodule
